// File: rtl/regfile_sb.sv
// Register file with write-through bypass and an issue scoreboard: one busy bit per
// register, RAW/WAW stall generation, and a running count of outstanding writes.

module regfile_sb_entry #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic              set,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q,
    output logic              busy
);

    // An issue landing on the same edge as the writeback keeps the entry busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            busy <= 1'b0;
        end else begin
            if (wr)
                q <= d;
            if (set)
                busy <= 1'b1;
            else if (wr)
                busy <= 1'b0;
        end
    end

endmodule

module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    input  logic              use_a,
    input  logic              use_b,
    output logic [DATA_W-1:0] qa,
    output logic [DATA_W-1:0] qb,
    input  logic              we,
    input  logic [ADDR_W-1:0] wn,
    input  logic [DATA_W-1:0] d,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dst,
    output logic              stall,
    output logic              busy_a,
    output logic              busy_b,
    output logic [ADDR_W:0]   pending_cnt
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    logic [NREGS-1:0][DATA_W-1:0] regs;
    logic [NREGS-1:0]             busy;
    logic                         wr_en;
    logic                         iss_ok;
    logic                         dst_haz;
    logic                         cnt_inc;
    logic                         cnt_dec;

    assign wr_en  = we & (wn != '0);
    assign iss_ok = iss_valid & ~stall;

    assign regs[0] = '0;
    assign busy[0] = 1'b0;

    genvar i;
    generate
        for (i = 1; i < NREGS; i++) begin : g_reg
            regfile_sb_entry #(.DATA_W(DATA_W)) u_entry (
                .clk   (clk),
                .rst_n (rst_n),
                .wr    (wr_en & (wn == ADDR_W'(i))),
                .set   (iss_ok & (iss_dst == ADDR_W'(i))),
                .d     (d),
                .q     (regs[i]),
                .busy  (busy[i])
            );
        end
    endgenerate

    // Bypass is masked during reset so reads return zero while rst_n is low.
    assign qa = (rst_n & wr_en & (wn == ra_addr)) ? d : regs[ra_addr];
    assign qb = (rst_n & wr_en & (wn == rb_addr)) ? d : regs[rb_addr];

    assign busy_a  = busy[ra_addr] & ~(we & (wn == ra_addr));
    assign busy_b  = busy[rb_addr] & ~(we & (wn == rb_addr));
    assign dst_haz = (iss_dst != '0) & busy[iss_dst] & ~(we & (wn == iss_dst));
    assign stall   = iss_valid & ((use_a & busy_a) | (use_b & busy_b) | dst_haz);

    // Same-index issue+writeback on a busy entry nets to zero; on an idle entry it is +1.
    assign cnt_inc = iss_ok & (iss_dst != '0);
    assign cnt_dec = wr_en & busy[wn];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_cnt <= '0;
        end else begin
            case ({cnt_inc, cnt_dec})
                2'b10:   pending_cnt <= pending_cnt + CNT_ONE;
                2'b01:   pending_cnt <= pending_cnt - CNT_ONE;
                default: pending_cnt <= pending_cnt;
            endcase
        end
    end

endmodule
